// File: rtl/bamf_pkg.sv
// Shared definitions for the buffered datapath selector: mode encodings and the
// default channel width that matches the existing 10-bit datapath.
package bamf_pkg;

  localparam logic MODE_DIRECTED = 1'b0;
  localparam logic MODE_RR       = 1'b1;

  localparam int DEFAULT_WIDTH = 10;

endpackage

// File: rtl/bmux_pipe_if.sv
// Bundle of the per-channel input handshakes, selection controls and the single
// output handshake of bmux_pipe. The slave side is the selector itself.
interface bmux_pipe_if
  import bamf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = 4
);

  localparam int SEL_W = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SEL_W-1:0]   sel;
  logic               mode;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_sel;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

endinterface

// File: rtl/bmux_rr_grant.sv
// Combinational round-robin arbiter: picks the first valid channel at or above
// the pointer, wrapping back to the lowest valid channel when none is found.
module bmux_rr_grant #(
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [SEL_W-1:0] i_ptr,
  input  logic [N-1:0]     i_valid,
  output logic [SEL_W-1:0] o_grant,
  output logic             o_grantValid
);

  logic [SEL_W-1:0] w_hiGrant;
  logic [SEL_W-1:0] w_loGrant;
  logic             w_hiFound;
  logic             w_loFound;

  // Scanning downward leaves the lowest qualifying index in each candidate.
  always_comb begin
    w_hiGrant = '0;
    w_loGrant = '0;
    w_hiFound = 1'b0;
    w_loFound = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_valid[i]) begin
        w_loGrant = SEL_W'(i);
        w_loFound = 1'b1;
        if (SEL_W'(i) >= i_ptr) begin
          w_hiGrant = SEL_W'(i);
          w_hiFound = 1'b1;
        end
      end
    end
    o_grant      = w_hiFound ? w_hiGrant : w_loGrant;
    o_grantValid = w_loFound;
  end

endmodule

// File: rtl/bmux_pipe.sv
// N-way selector with directed or round-robin grant, delivering the chosen word
// through a two-entry skid stage (main register M, skid register S).
module bmux_pipe
  import bamf_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic     clk,
  input  logic     rst,
  bmux_pipe_if.slave bus
);

  logic [SEL_W-1:0] r_ptr;
  logic             r_mValid;
  logic [WIDTH-1:0] r_mData;
  logic [SEL_W-1:0] r_mSel;
  logic             r_sValid;
  logic [WIDTH-1:0] r_sData;
  logic [SEL_W-1:0] r_sSel;

  logic [SEL_W-1:0] w_rrGrant;
  logic             w_rrValid;
  logic             w_dirValid;
  logic [SEL_W-1:0] w_grant;
  logic             w_grantValid;
  logic             w_accept;
  logic             w_outXfer;
  logic [WIDTH-1:0] w_inWord;
  logic [N-1:0]     w_inReady;

  bmux_rr_grant #(.N(N)) u_rrGrant (
    .i_ptr        (r_ptr),
    .i_valid      (bus.in_valid),
    .o_grant      (w_rrGrant),
    .o_grantValid (w_rrValid)
  );

  // Matching sel against each legal index keeps out-of-range selects from granting.
  always_comb begin
    w_dirValid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
        w_dirValid = 1'b1;
      end
    end
    if (bus.mode == MODE_DIRECTED) begin
      w_grant      = bus.sel;
      w_grantValid = w_dirValid;
    end else begin
      w_grant      = w_rrGrant;
      w_grantValid = w_rrValid;
    end
    w_accept  = w_grantValid && !r_sValid && !rst;
    w_outXfer = r_mValid && bus.out_ready;
    w_inWord  = '0;
    w_inReady = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant == SEL_W'(i)) begin
        w_inWord     = bus.in_data[i*WIDTH +: WIDTH];
        w_inReady[i] = w_accept;
      end
    end
  end

  assign bus.in_ready = w_inReady;

  // S only fills while M is stalled, so an accept never coincides with S full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      r_mValid <= 1'b0;
      r_mData  <= '0;
      r_mSel   <= '0;
      r_sValid <= 1'b0;
      r_sData  <= '0;
      r_sSel   <= '0;
    end else begin
      if (w_accept && bus.mode == MODE_RR) begin
        r_ptr <= (w_grant == SEL_W'(N - 1)) ? '0 : w_grant + 1'b1;
      end
      if (r_sValid) begin
        if (bus.out_ready) begin
          r_mData  <= r_sData;
          r_mSel   <= r_sSel;
          r_sValid <= 1'b0;
        end
      end else if (w_accept) begin
        if (!r_mValid || bus.out_ready) begin
          r_mData  <= w_inWord;
          r_mSel   <= w_grant;
          r_mValid <= 1'b1;
        end else begin
          r_sData  <= w_inWord;
          r_sSel   <= w_grant;
          r_sValid <= 1'b1;
        end
      end else if (w_outXfer) begin
        r_mValid <= 1'b0;
      end
    end
  end

  assign bus.out_data  = r_mData;
  assign bus.out_sel   = r_mSel;
  assign bus.out_valid = r_mValid;

endmodule

// File: tb/tb_bmux_pipe.sv
// Drives a 4-channel and a 3-channel selector in lockstep and compares both
// against a per-instance reference model of grant rules and a two-deep queue.
module tb_bmux_pipe;
  import bamf_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [39:0] drvData;
  logic [3:0]  drvValid;
  logic [1:0]  drvSel;
  logic        drvMode;
  logic        drvOutReady;

  bmux_pipe_if #(.WIDTH(10), .N(4)) bus4 ();
  bmux_pipe_if #(.WIDTH(10), .N(3)) bus3 ();

  assign bus4.in_data   = drvData;
  assign bus4.in_valid  = drvValid;
  assign bus4.sel       = drvSel;
  assign bus4.mode      = drvMode;
  assign bus4.out_ready = drvOutReady;
  assign bus3.in_data   = drvData[29:0];
  assign bus3.in_valid  = drvValid[2:0];
  assign bus3.sel       = drvSel;
  assign bus3.mode      = drvMode;
  assign bus3.out_ready = drvOutReady;

  bmux_pipe #(.WIDTH(10), .N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  bmux_pipe #(.WIDTH(10), .N(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  logic [3:0] obsReady [2];
  logic       obsValid [2];
  logic [9:0] obsData  [2];
  logic [1:0] obsSel   [2];

  assign obsReady[0] = bus4.in_ready;
  assign obsReady[1] = {1'b0, bus3.in_ready};
  assign obsValid[0] = bus4.out_valid;
  assign obsValid[1] = bus3.out_valid;
  assign obsData[0]  = bus4.out_data;
  assign obsData[1]  = bus3.out_data;
  assign obsSel[0]   = bus4.out_sel;
  assign obsSel[1]   = bus3.out_sel;

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per instance: index 0 has 4 channels, 1 has 3.
  int         nCh [2] = '{4, 3};
  int         cnt [2];
  int         ptr [2];
  logic [9:0] fData [2][2];
  logic [1:0] fSel  [2][2];
  logic [9:0] shownData [2];
  logic [1:0] shownSel  [2];
  int         pGrant [2];
  bit         pAcc   [2];
  bit         modelValid = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [39:0] pack4(input logic [9:0] a, input logic [9:0] b,
                                        input logic [9:0] c, input logic [9:0] e);
    return {e, c, b, a};
  endfunction

  function automatic void predictGrant(input int d, output int g, output bit gv);
    int v;
    int idx;
    v  = int'(drvValid) & ((1 << nCh[d]) - 1);
    g  = 0;
    gv = 1'b0;
    if (drvMode == MODE_DIRECTED) begin
      g  = int'(drvSel);
      gv = (g < nCh[d]) && (((v >> g) & 1) == 1);
    end else begin
      for (int k = 0; k < nCh[d]; k++) begin
        idx = (ptr[d] + k) % nCh[d];
        if (!gv && (((v >> idx) & 1) == 1)) begin
          gv = 1'b1;
          g  = idx;
        end
      end
    end
  endfunction

  task automatic modelCheck(input int d);
    int   g;
    bit   gv;
    logic [31:0] expReady;
    predictGrant(d, g, gv);
    pGrant[d] = g;
    pAcc[d]   = gv && !rst && (cnt[d] < 2);
    expReady  = pAcc[d] ? (32'd1 << g) : 32'd0;
    checkOutput($sformatf("n%0d_in_ready", nCh[d]), 32'(obsReady[d]), expReady);
    if (modelValid) begin
      checkOutput($sformatf("n%0d_out_valid", nCh[d]), 32'(obsValid[d]), 32'(cnt[d] > 0));
      checkOutput($sformatf("n%0d_out_data", nCh[d]), 32'(obsData[d]), 32'(shownData[d]));
      checkOutput($sformatf("n%0d_out_sel", nCh[d]), 32'(obsSel[d]), 32'(shownSel[d]));
    end
  endtask

  task automatic modelUpdate(input int d);
    if (rst) begin
      cnt[d]       = 0;
      ptr[d]       = 0;
      shownData[d] = '0;
      shownSel[d]  = '0;
    end else begin
      if (cnt[d] > 0 && drvOutReady) begin
        fData[d][0] = fData[d][1];
        fSel[d][0]  = fSel[d][1];
        cnt[d]--;
      end
      if (pAcc[d]) begin
        fData[d][cnt[d]] = drvData[pGrant[d]*10 +: 10];
        fSel[d][cnt[d]]  = 2'(pGrant[d]);
        cnt[d]++;
        if (drvMode == MODE_RR) ptr[d] = (pGrant[d] + 1) % nCh[d];
      end
      if (cnt[d] > 0) begin
        shownData[d] = fData[d][0];
        shownSel[d]  = fSel[d][0];
      end
    end
  endtask

  // Checks just after inputs settle, advances the model at the edge, then
  // leaves time 1 unit past the edge so callers can inspect the new state.
  task automatic applyStimulus(input logic r, input logic m, input logic [1:0] s,
                               input logic [3:0] v, input logic outRdy, input logic [39:0] data);
    @(negedge clk);
    rst         = r;
    drvMode     = m;
    drvSel      = s;
    drvValid    = v;
    drvOutReady = outRdy;
    drvData     = data;
    #1;
    modelCheck(0);
    modelCheck(1);
    @(posedge clk);
    modelUpdate(0);
    modelUpdate(1);
    if (rst) modelValid = 1'b1;
    #1;
  endtask

  logic [9:0]  bw [3] = '{10'h001, 10'h002, 10'h003};
  int          k;
  logic [39:0] rndData;

  initial begin
    rst = 1'b1; drvMode = MODE_DIRECTED; drvSel = '0; drvValid = '0; drvOutReady = 1'b0; drvData = '0;
    applyStimulus(1'b1, MODE_DIRECTED, 2'd0, 4'b0000, 1'b0, 40'd0);
    applyStimulus(1'b1, MODE_DIRECTED, 2'd0, 4'b0000, 1'b0, 40'd0);
    checkOutput("reset_out_valid", 32'(obsValid[0]), 32'd0);
    checkOutput("reset_out_data", 32'(obsData[0]), 32'd0);
    checkOutput("reset_out_sel", 32'(obsSel[0]), 32'd0);

    // Directed pass-through on channel 2.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, MODE_DIRECTED, 2'd2, 4'b0100, 1'b1, pack4(10'h0, 10'h0, 10'h155, 10'h0));
      checkOutput("dir_out_valid", 32'(obsValid[0]), 32'd1);
      checkOutput("dir_out_data", 32'(obsData[0]), 32'h155);
      checkOutput("dir_out_sel", 32'(obsSel[0]), 32'd2);
      checkOutput("dir_in_ready", 32'(obsReady[0]), 32'b0100);
    end
    applyStimulus(1'b0, MODE_DIRECTED, 2'd0, 4'b0000, 1'b1, 40'd0);
    applyStimulus(1'b0, MODE_DIRECTED, 2'd0, 4'b0000, 1'b1, 40'd0);

    // Backpressure: two words absorbed by M and S, the third waits.
    k = 0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, MODE_DIRECTED, 2'd1, (k < 3) ? 4'b0010 : 4'b0000, 1'b0,
                    pack4(10'h0, bw[(k < 3) ? k : 2], 10'h0, 10'h0));
      if (pAcc[0]) k++;
    end
    checkOutput("bp_accepts", 32'(k), 32'd2);
    checkOutput("bp_hold_data", 32'(obsData[0]), 32'h001);
    checkOutput("bp_ready_low", 32'(obsReady[0]), 32'd0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, MODE_DIRECTED, 2'd1, (k < 3) ? 4'b0010 : 4'b0000, 1'b1,
                    pack4(10'h0, bw[(k < 3) ? k : 2], 10'h0, 10'h0));
      if (pAcc[0]) k++;
      if (c < 2) checkOutput("bp_drain_data", 32'(obsData[0]), 32'(bw[c+1]));
    end
    checkOutput("bp_drain_empty", 32'(obsValid[0]), 32'd0);
    checkOutput("bp_empty_hold", 32'(obsData[0]), 32'h003);

    // Round-robin with every channel valid.
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, MODE_RR, 2'd0, 4'b1111, 1'b1, pack4(10'h100, 10'h101, 10'h102, 10'h103));
      checkOutput("rr_sel", 32'(obsSel[0]), 32'(c % 4));
      checkOutput("rr_data", 32'(obsData[0]), 32'h100 + 32'(c % 4));
    end

    // Sparse round-robin with wrap on the 3-channel instance.
    applyStimulus(1'b1, MODE_RR, 2'd0, 4'b0000, 1'b1, 40'd0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, MODE_RR, 2'd0, 4'b0101, 1'b1, pack4(10'h200, 10'h201, 10'h202, 10'h203));
      checkOutput("sparse_sel_n3", 32'(obsSel[1]), 32'((c % 2) * 2));
      checkOutput("sparse_sel_n4", 32'(obsSel[0]), 32'((c % 2) * 2));
    end

    // Fill both registers, then reset in the middle of operation.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, MODE_DIRECTED, 2'd0, 4'b0001, 1'b0, pack4(10'h300, 10'h301, 10'h302, 10'h303));
    end
    checkOutput("full_out_valid", 32'(obsValid[0]), 32'd1);
    applyStimulus(1'b1, MODE_DIRECTED, 2'd0, 4'b0001, 1'b0, pack4(10'h300, 10'h301, 10'h302, 10'h303));
    checkOutput("midrst_out_valid", 32'(obsValid[0]), 32'd0);
    checkOutput("midrst_out_data", 32'(obsData[0]), 32'd0);
    checkOutput("midrst_out_sel", 32'(obsSel[0]), 32'd0);
    applyStimulus(1'b0, MODE_RR, 2'd0, 4'b1111, 1'b1, pack4(10'h310, 10'h311, 10'h312, 10'h313));
    checkOutput("post_rst_rr_sel", 32'(obsSel[0]), 32'd0);
    checkOutput("post_rst_rr_data", 32'(obsData[0]), 32'h310);

    // Out-of-range directed select on the 3-channel instance.
    applyStimulus(1'b1, MODE_DIRECTED, 2'd0, 4'b0000, 1'b1, 40'd0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, MODE_DIRECTED, 2'd3, 4'b1111, 1'b1, pack4(10'h3a0, 10'h3a1, 10'h3a2, 10'h3a3));
      checkOutput("oor_in_ready_n3", 32'(obsReady[1]), 32'd0);
      checkOutput("oor_out_valid_n3", 32'(obsValid[1]), 32'd0);
    end

    // Randomized traffic, occasional resets, random modes and backpressure.
    for (int c = 0; c < 400; c++) begin
      rndData = {8'($urandom()), 32'($urandom())};
      applyStimulus(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 3) != 0), rndData);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bmux_pipe.md
Name: bmux_pipe

Overview:
- Parametrised, registered successor to the processor's fixed 4:1 datapath selectors.
- Selects one of N source channels, each with its own valid/ready handshake, and delivers the chosen word through a 2-entry skid output stage.
- Two selection modes: directed, where the select port names the source, and round-robin, where the block grants among valid sources in turn.
- Sits between operand/result producers (register file, ALU, immediate path) and a downstream consumer that may stall.

Parameters:
WIDTH, 10, data width per channel
N, 4, number of input channels (2..16)
SEL_W, $clog2(N), select width (localparam, not overridable)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_data  in  N*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
in_valid  in  N  per-channel valid
in_ready  out  N  per-channel ready; at most one bit high
sel  in  SEL_W  directed-mode source index
mode  in  1  0 = directed, 1 = round-robin
out_data  out  WIDTH  selected word
out_sel  out  SEL_W  index of the channel that supplied out_data
out_valid  out  1  output word valid
out_ready  in  1  downstream accept

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: out_valid=0, out_data=0, out_sel=0, skid empty, RR pointer=0. in_ready=0 during the cycle rst is high.
- Reset mid-operation discards both buffered words. No transfer completes in a cycle where rst=1.
- Transfer rules:
  - Input transfer on channel i when in_valid[i] && in_ready[i].
  - Output transfer when out_valid && out_ready.
- Grant, combinational:
  - Directed: grant = sel if sel < N && in_valid[sel]; otherwise no grant.
  - Round-robin: grant = first i with in_valid[i], searching from ptr upward with wrap at N-1 -> 0.
  - in_ready[grant] = !skid_valid && !rst. All other in_ready bits are 0.
  - in_ready may depend combinationally on in_valid and sel. Sources must not make in_valid depend on in_ready.
- RR pointer:
  - Updates only on an accepted transfer in round-robin mode: ptr <= (grant == N-1) ? 0 : grant+1.
  - Holds in directed mode.
  - A mode change takes effect in the same cycle for grant; the pointer is preserved.
- Skid stage (main register M, skid register S):
  - Latency: an accepted word appears on out_data/out_sel/out_valid the next cycle.
  - Accept with M empty, or M draining (out_ready=1): word -> M.
  - Accept with M full and out_ready=0: word -> S. in_ready drops the next cycle.
  - Output transfer with S full: S -> M, S empties, M stays valid.
  - Output transfer with S empty and no accept: M empties, out_valid=0 next cycle.
  - Simultaneous accept and output transfer with S empty: new word replaces M, out_valid stays 1.
  - S is never written while full, so no overflow is possible.
- Output stability: out_data and out_sel hold while out_valid && !out_ready. When M is empty, out_data/out_sel hold their last value and are not zeroed.
- Sustained throughput: 1 word/cycle when out_ready=1 continuously.
- Word ordering: words leave in acceptance order.

Decomposition:
- Shared package bamf_pkg holds MODE_DIRECTED=1'b0, MODE_RR=1'b1, and default data width 10 (to match the existing 10-bit datapath).
- One sub-module: bmux_rr_grant (N, ptr, in_valid -> grant index + grant_valid), purely combinational.
- Skid stage stays inline.

Test Plan:
- Directed pass-through, N=4, WIDTH=10: sel=2, in_valid=4'b0100, in_data ch2=10'h155, out_ready=1 -> next cycle out_valid=1, out_data=10'h155, out_sel=2. in_ready=4'b0100 throughout.
- Backpressure: directed sel=1, ch1 presents 10'h001, 10'h002, 10'h003 back-to-back, out_ready=0 -> in_ready[1] high for two accepts then low. out_data holds 10'h001. Raising out_ready yields 001, 002, 003 in order on consecutive cycles.
- Round-robin fairness: mode=1, in_valid=4'b1111 constant, out_ready=1 -> out_sel sequence 0,1,2,3,0,1,... with each channel's data.
- Sparse RR plus wrap with N=3: in_valid=3'b101, ptr starts 0 -> grants 0,2,0,2. Ptr wraps 2->0.
- Out-of-range directed select with N=3: sel=3, all valid -> in_ready=0, out_valid stays 0 from empty.
- Reset mid-operation: M and S full, out_ready=0, assert rst one cycle -> next cycle out_valid=0, out_data=0, out_sel=0. The first post-reset RR grant goes to channel 0.
